// File: rtl/edm_pkg.sv
// Shared EDM definitions: mos_control state encodings, profile record and
// scheduler FSM encoding.
package edm_pkg;

  localparam logic [7:0] MOS_WAIT_BREAKDOWN  = 8'h01;
  localparam logic [7:0] MOS_BUCK_INTERLEAVE = 8'h02;
  localparam logic [7:0] MOS_RES_DISCHARGE   = 8'h04;
  localparam logic [7:0] MOS_DEION           = 8'h80;

  typedef struct packed {
    logic [15:0] waveform;
    logic [15:0] ip;
    logic [15:0] ton;
    logic [15:0] toff;
    logic [15:0] icharge;
    logic [15:0] count;
  } profile_t;

  typedef enum logic [1:0] {
    SCH_IDLE = 2'd0,
    SCH_LOAD = 2'd1,
    SCH_RUN  = 2'd2,
    SCH_STOP = 2'd3
  } sched_state_e;

  function automatic logic is_discharge_phase(input logic [7:0] st);
    return (st == MOS_BUCK_INTERLEAVE) || (st == MOS_RES_DISCHARGE);
  endfunction

endpackage

// File: rtl/profile_fifo.sv
// Synchronous FIFO with level output; pointers carry an extra wrap bit so
// full and empty can be told apart.
module profile_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q, level_q;
  logic             push_s, pop_s;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      case ({push_s, pop_s})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pulse_param_scheduler.sv
// Feeds queued discharge profiles to mos_control, swapping at pulse ends.
// Optional event counters are built when PULSE_STATS_EN is defined.
module pulse_param_scheduler
  import edm_pkg::*;
#(
  parameter int          PROFILE_DEPTH = 4,
  parameter logic [15:0] DEFAULT_TOFF  = 16'd1000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           run_req,
  input  logic                           flush,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [15:0]                    cfg_waveform,
  input  logic [15:0]                    cfg_ip,
  input  logic [15:0]                    cfg_ton,
  input  logic [15:0]                    cfg_toff,
  input  logic [15:0]                    cfg_icharge,
  input  logic [15:0]                    cfg_count,
  output logic                           cfg_err,
  input  logic [7:0]                     mos_state,
  output logic                           is_machine_start,
  output logic [15:0]                    waveform,
  output logic [15:0]                    Ip,
  output logic [15:0]                    Ton,
  output logic [15:0]                    Toff,
  output logic [15:0]                    inductor_charging_time,
  output logic                           busy,
  output logic                           profile_done,
  output logic [$clog2(PROFILE_DEPTH):0] fifo_level,
  output logic [31:0]                    pulse_total,
  output logic [31:0]                    open_total
);

  localparam profile_t ACT_RST = '{waveform: 16'd0, ip: 16'd0, ton: 16'd0,
                                   toff: DEFAULT_TOFF, icharge: 16'd0, count: 16'd0};

  profile_t     cfg_s, head_s, act_q, act_d;
  sched_state_e state_q, state_d;
  logic [15:0]  remaining_q, remaining_d;
  logic [7:0]   prev_state_q;
  logic         pulse_evt_q;
  logic         full_s, empty_s, push_s, pop_s, flush_s;
  logic         start_q, start_d, busy_q, busy_d, done_q, done_d, err_q;

  assign cfg_s     = '{waveform: cfg_waveform, ip: cfg_ip, ton: cfg_ton,
                       toff: cfg_toff, icharge: cfg_icharge, count: cfg_count};
  assign cfg_ready = !full_s;
  assign push_s    = cfg_valid && !full_s && (cfg_ton != 16'd0);
  assign flush_s   = flush && (state_q == SCH_IDLE);

  profile_fifo #(.DEPTH(PROFILE_DEPTH), .WIDTH($bits(profile_t))) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_s),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (cfg_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .level_o (fifo_level)
  );

  // Pulse-end detection is registered, so swaps land two cycles after DEION entry
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_state_q <= 8'h00;
      pulse_evt_q  <= 1'b0;
    end else begin
      prev_state_q <= mos_state;
      pulse_evt_q  <= is_discharge_phase(prev_state_q) && (mos_state == MOS_DEION);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCH_IDLE;
      act_q       <= ACT_RST;
      remaining_q <= 16'd0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      remaining_q <= remaining_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= cfg_valid && !full_s && (cfg_ton == 16'd0);
    end
  end

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    remaining_d = remaining_q;
    pop_s       = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      SCH_IDLE: begin
        if (run_req && !empty_s) state_d = SCH_LOAD;
        else                     state_d = SCH_IDLE;
      end
      SCH_LOAD: begin
        pop_s       = 1'b1;
        act_d       = head_s;
        remaining_d = head_s.count;
        state_d     = SCH_RUN;
      end
      SCH_RUN: begin
        if (!run_req) begin
          state_d = SCH_STOP;
        end else if (pulse_evt_q) begin
          // count 0 means "run until a newer profile is queued"
          if (act_q.count != 16'd0) begin
            if (remaining_q != 16'd0) remaining_d = remaining_q - 16'd1;
            else                      remaining_d = remaining_q;
            if (remaining_q <= 16'd1) begin
              done_d = 1'b1;
              if (!empty_s) begin
                pop_s       = 1'b1;
                act_d       = head_s;
                remaining_d = head_s.count;
              end else begin
                state_d = SCH_STOP;
              end
            end else begin
              state_d = SCH_RUN;
            end
          end else if (!empty_s) begin
            pop_s       = 1'b1;
            act_d       = head_s;
            remaining_d = head_s.count;
          end else begin
            state_d = SCH_RUN;
          end
        end else begin
          state_d = SCH_RUN;
        end
      end
      SCH_STOP: begin
        if (mos_state == MOS_DEION) state_d = SCH_IDLE;
        else                        state_d = SCH_STOP;
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  always_comb begin
    start_d = 1'b0;
    busy_d  = 1'b1;
    case (state_d)
      SCH_IDLE: busy_d  = 1'b0;
      SCH_RUN:  start_d = 1'b1;
      default:  start_d = 1'b0;
    endcase
  end

  assign is_machine_start       = start_q;
  assign busy                   = busy_q;
  assign profile_done           = done_q;
  assign cfg_err                = err_q;
  assign waveform               = act_q.waveform;
  assign Ip                     = act_q.ip;
  assign Ton                    = act_q.ton;
  assign Toff                   = act_q.toff;
  assign inductor_charging_time = act_q.icharge;

`ifdef PULSE_STATS_EN
  logic        open_evt_q;
  logic [31:0] pulse_total_q, open_total_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      open_evt_q    <= 1'b0;
      pulse_total_q <= 32'd0;
      open_total_q  <= 32'd0;
    end else begin
      open_evt_q <= (prev_state_q == MOS_WAIT_BREAKDOWN) && (mos_state == MOS_DEION);
      if (pulse_evt_q && (pulse_total_q != 32'hFFFF_FFFF)) pulse_total_q <= pulse_total_q + 32'd1;
      if (open_evt_q && (open_total_q != 32'hFFFF_FFFF))   open_total_q  <= open_total_q + 32'd1;
    end
  end

  assign pulse_total = pulse_total_q;
  assign open_total  = open_total_q;
`else
  assign pulse_total = 32'd0;
  assign open_total  = 32'd0;
`endif

endmodule

// File: tb/tb_pulse_param_scheduler.sv
// Directed bench for pulse_param_scheduler (default parameters).
module tb_pulse_param_scheduler;

  localparam logic [7:0] WAITB = 8'h01;
  localparam logic [7:0] BUCK  = 8'h02;
  localparam logic [7:0] RES   = 8'h04;
  localparam logic [7:0] DEION = 8'h80;
`ifdef PULSE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, run_req, flush, cfg_valid, cfg_ready, cfg_err;
  logic [15:0] cfg_waveform, cfg_ip, cfg_ton, cfg_toff, cfg_icharge, cfg_count;
  logic [7:0]  mos_state;
  logic        is_machine_start, busy, profile_done;
  logic [15:0] waveform, Ip, Ton, Toff, inductor_charging_time;
  logic [2:0]  fifo_level;
  logic [31:0] pulse_total, open_total;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pulse_param_scheduler dut (
    .clk(clk), .rst(rst), .run_req(run_req), .flush(flush),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_waveform(cfg_waveform), .cfg_ip(cfg_ip), .cfg_ton(cfg_ton),
    .cfg_toff(cfg_toff), .cfg_icharge(cfg_icharge), .cfg_count(cfg_count),
    .cfg_err(cfg_err), .mos_state(mos_state),
    .is_machine_start(is_machine_start), .waveform(waveform), .Ip(Ip),
    .Ton(Ton), .Toff(Toff), .inductor_charging_time(inductor_charging_time),
    .busy(busy), .profile_done(profile_done), .fifo_level(fifo_level),
    .pulse_total(pulse_total), .open_total(open_total)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_prof(input logic [15:0] ton, input logic [15:0] toff, input logic [15:0] cnt);
    cfg_valid    = 1'b1;
    cfg_waveform = 16'd1;
    cfg_ip       = 16'd10;
    cfg_ton      = ton;
    cfg_toff     = toff;
    cfg_icharge  = 16'd20;
    cfg_count    = cnt;
    step();
    cfg_valid    = 1'b0;
  endtask

  // Controller model: one phase cycle, then DEION held across the two-cycle swap latency
  task automatic do_pulse(input logic [7:0] phase);
    mos_state = phase;
    step();
    mos_state = DEION;
    step();
    step();
  endtask

  initial begin
    rst = 1'b1; run_req = 1'b0; flush = 1'b0; cfg_valid = 1'b0;
    cfg_waveform = 16'd0; cfg_ip = 16'd0; cfg_ton = 16'd0;
    cfg_toff = 16'd0; cfg_icharge = 16'd0; cfg_count = 16'd0;
    mos_state = DEION;
    step(); step();
    rst = 1'b0;
    check_eq("rst_start", is_machine_start, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_toff", Toff, 16'd1000);
    check_eq("rst_ton", Ton, 16'd0);
    check_eq("rst_level", fifo_level, 3'd0);
    check_eq("rst_ready", cfg_ready, 1'b1);
    check_eq("rst_done", profile_done, 1'b0);
    check_eq("rst_ptotal", pulse_total, 32'd0);

    // single counted profile
    push_prof(16'd300, 16'd500, 16'd3);
    check_eq("t1_level", fifo_level, 3'd1);
    run_req = 1'b1;
    step();
    check_eq("t1_load_start", is_machine_start, 1'b0);
    check_eq("t1_load_busy", busy, 1'b1);
    step();
    check_eq("t1_run_start", is_machine_start, 1'b1);
    check_eq("t1_ton", Ton, 16'd300);
    check_eq("t1_toff", Toff, 16'd500);
    check_eq("t1_ich", inductor_charging_time, 16'd20);
    check_eq("t1_level0", fifo_level, 3'd0);
    do_pulse(BUCK);
    do_pulse(BUCK);
    check_eq("t1_done_early", profile_done, 1'b0);
    do_pulse(RES);
    check_eq("t1_done", profile_done, 1'b1);
    check_eq("t1_stop_start", is_machine_start, 1'b0);
    step();
    check_eq("t1_done_clr", profile_done, 1'b0);
    check_eq("t1_idle_busy", busy, 1'b0);
    check_eq("t1_ton_hold", Ton, 16'd300);
    check_eq("t1_ptotal", pulse_total, STATS ? 32'd3 : 32'd0);
    run_req = 1'b0;

    // counted profile then open-ended one: swap exactly two cycles after DEION
    push_prof(16'd100, 16'd200, 16'd2);
    push_prof(16'd400, 16'd600, 16'd0);
    run_req = 1'b1;
    step(); step();
    check_eq("t2_ton_a", Ton, 16'd100);
    check_eq("t2_level", fifo_level, 3'd1);
    do_pulse(BUCK);
    mos_state = BUCK;
    step();
    mos_state = DEION;
    step();
    check_eq("t2_ton_1cyc", Ton, 16'd100);
    step();
    check_eq("t2_ton_b", Ton, 16'd400);
    check_eq("t2_toff_b", Toff, 16'd600);
    check_eq("t2_done", profile_done, 1'b1);
    check_eq("t2_start", is_machine_start, 1'b1);
    check_eq("t2_level0", fifo_level, 3'd0);
    for (int i = 0; i < 3; i++) do_pulse(RES);
    check_eq("t2_ton_keep", Ton, 16'd400);
    check_eq("t2_start_keep", is_machine_start, 1'b1);
    check_eq("t2_no_done", profile_done, 1'b0);
    check_eq("t2_ptotal", pulse_total, STATS ? 32'd8 : 32'd0);
    run_req = 1'b0;
    step();
    check_eq("t2_stop_start", is_machine_start, 1'b0);
    step();
    check_eq("t2_idle_busy", busy, 1'b0);

    // FIFO full back-pressure
    for (int i = 0; i < 4; i++) push_prof(16'd11 + 16'(i), 16'd100, 16'd1);
    check_eq("t3_level4", fifo_level, 3'd4);
    check_eq("t3_ready0", cfg_ready, 1'b0);
    cfg_valid = 1'b1; cfg_ton = 16'd15; cfg_toff = 16'd100; cfg_count = 16'd1;
    run_req = 1'b1;
    step();
    check_eq("t3_full_hold", fifo_level, 3'd4);
    step();
    check_eq("t3_level3", fifo_level, 3'd3);
    check_eq("t3_ready1", cfg_ready, 1'b1);
    check_eq("t3_ton", Ton, 16'd11);
    step();
    cfg_valid = 1'b0;
    check_eq("t3_level4b", fifo_level, 3'd4);
    do_pulse(BUCK);
    check_eq("t3_next_ton", Ton, 16'd12);
    check_eq("t3_level3b", fifo_level, 3'd3);
    rst = 1'b1; run_req = 1'b0;
    step();
    rst = 1'b0;

    // open events leave the pulse count alone
    push_prof(16'd50, 16'd100, 16'd2);
    run_req = 1'b1;
    step(); step();
    for (int i = 0; i < 4; i++) do_pulse(WAITB);
    check_eq("t4_no_done", profile_done, 1'b0);
    check_eq("t4_ton", Ton, 16'd50);
    check_eq("t4_start", is_machine_start, 1'b1);
    check_eq("t4_otot", open_total, STATS ? 32'd4 : 32'd0);
    do_pulse(BUCK);
    check_eq("t4_done_early", profile_done, 1'b0);
    do_pulse(BUCK);
    check_eq("t4_done", profile_done, 1'b1);
    check_eq("t4_ptotal", pulse_total, STATS ? 32'd2 : 32'd0);
    step();
    run_req = 1'b0;
    check_eq("t4_idle", busy, 1'b0);

    // Ton==0 is dropped; flush empties in IDLE
    push_prof(16'd0, 16'd100, 16'd1);
    check_eq("t5_err", cfg_err, 1'b1);
    check_eq("t5_level", fifo_level, 3'd0);
    step();
    check_eq("t5_err_clr", cfg_err, 1'b0);
    push_prof(16'd7, 16'd100, 16'd1);
    check_eq("t5_level1", fifo_level, 3'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("t5_flush", fifo_level, 3'd0);

    // reset in the middle of RUN
    push_prof(16'd70, 16'd700, 16'd0);
    push_prof(16'd80, 16'd800, 16'd0);
    run_req = 1'b1;
    step(); step();
    check_eq("t6_toff", Toff, 16'd700);
    check_eq("t6_start", is_machine_start, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_req = 1'b0;
    check_eq("t6_rst_start", is_machine_start, 1'b0);
    check_eq("t6_rst_toff", Toff, 16'd1000);
    check_eq("t6_rst_level", fifo_level, 3'd0);
    check_eq("t6_rst_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
